// File: rtl/pspin_her_arb_pkg.sv
// pspin_her_arb_pkg: shared PsPIN parameters for the HER arbiter and HER generator.
package pspin_her_arb_pkg;
  localparam int NUM_PORTS = 4;
  localparam int MAX_INFLIGHT = 16;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int HER_ADDR_WIDTH = 32;
  localparam int HER_LEN_WIDTH = 20;
  localparam int HER_TAG_WIDTH = 32;
endpackage

// File: rtl/pspin_her_arb_if.sv
// pspin_her_arb_if: ingress completion requests and the HER generator beat.
interface pspin_her_arb_if #(
  parameter int NUM_PORTS = pspin_her_arb_pkg::NUM_PORTS,
  parameter int AXI_ADDR_WIDTH = pspin_her_arb_pkg::HER_ADDR_WIDTH,
  parameter int LEN_WIDTH = pspin_her_arb_pkg::HER_LEN_WIDTH,
  parameter int TAG_WIDTH = pspin_her_arb_pkg::HER_TAG_WIDTH,
  parameter int PORT_W = $clog2(NUM_PORTS)
);
  logic [NUM_PORTS*AXI_ADDR_WIDTH-1:0] in_addr;
  logic [NUM_PORTS*LEN_WIDTH-1:0] in_len;
  logic [NUM_PORTS*TAG_WIDTH-1:0] in_tag;
  logic [NUM_PORTS-1:0] in_valid;
  logic [NUM_PORTS-1:0] in_ready;
  logic [AXI_ADDR_WIDTH-1:0] gen_addr;
  logic [LEN_WIDTH-1:0] gen_len;
  logic [TAG_WIDTH-1:0] gen_tag;
  logic [PORT_W-1:0] gen_port;
  logic gen_valid;
  logic gen_ready;
  modport slave (
    input in_addr, in_len, in_tag, in_valid, gen_ready,
    output in_ready, gen_addr, gen_len, gen_tag, gen_port, gen_valid
  );
  modport master (
    output in_addr, in_len, in_tag, in_valid, gen_ready,
    input in_ready, gen_addr, gen_len, gen_tag, gen_port, gen_valid
  );
endinterface

// File: rtl/pspin_rr_arbiter.sv
// pspin_rr_arbiter: round-robin pick of the first request at or after ptr.
module pspin_rr_arbiter #(
  parameter int NUM_PORTS = pspin_her_arb_pkg::NUM_PORTS,
  localparam int PORT_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]    idx,
  output logic                 any
);
  import pspin_her_arb_pkg::*;
  always_comb begin
    idx = ptr;
    // scan downward so the nearest request to ptr is the last one written
    for (int k = NUM_PORTS - 1; k >= 0; k--)
      if (req[ptr + PORT_W'(k)]) idx = ptr + PORT_W'(k);
    any = |req;
    gnt = any ? NUM_PORTS'(1) << idx : '0;
  end
endmodule

// File: rtl/pspin_her_arb.sv
// pspin_her_arb: arbitrates ingress DMA completions into a single registered HER beat under an inflight limit.
module pspin_her_arb #(
  parameter int NUM_PORTS = pspin_her_arb_pkg::NUM_PORTS,
  parameter int AXI_ADDR_WIDTH = pspin_her_arb_pkg::HER_ADDR_WIDTH,
  parameter int LEN_WIDTH = pspin_her_arb_pkg::HER_LEN_WIDTH,
  parameter int TAG_WIDTH = pspin_her_arb_pkg::HER_TAG_WIDTH,
  parameter int MAX_INFLIGHT = pspin_her_arb_pkg::MAX_INFLIGHT,
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1),
  localparam int PORT_W = $clog2(NUM_PORTS)
) (
  input  logic             clk,
  input  logic             rstn,
  pspin_her_arb_if.slave   bus,
  input  logic             her_done,
  input  logic             enable,
  input  logic [CNT_W-1:0] inflight_limit,
  output logic [CNT_W-1:0] inflight_count,
  output logic             underflow_err
);
  import pspin_her_arb_pkg::*;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  logic [NUM_PORTS-1:0] gnt;
  logic [PORT_W-1:0] idx, rr_ptr_q, rr_ptr_d, gen_port_q, gen_port_d;
  logic any, grant, accept, can_issue, slot_free;
  logic [CNT_W-1:0] limit, cnt_q, cnt_d;
  logic err_q, err_d, gen_valid_q, gen_valid_d;
  logic [AXI_ADDR_WIDTH-1:0] gen_addr_q, gen_addr_d;
  logic [LEN_WIDTH-1:0] gen_len_q, gen_len_d;
  logic [TAG_WIDTH-1:0] gen_tag_q, gen_tag_d;
  pspin_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req(bus.in_valid), .ptr(rr_ptr_q), .gnt(gnt), .idx(idx), .any(any)
  );
  always_comb begin
    limit = inflight_limit > MAX_CNT ? MAX_CNT : inflight_limit;
    // a held beat already owns one slot of the budget
    can_issue = enable && ({1'b0, cnt_q} + {{CNT_W{1'b0}}, gen_valid_q}) < {1'b0, limit};
    slot_free = !gen_valid_q || bus.gen_ready;
    grant = slot_free && can_issue && any;
    accept = gen_valid_q && bus.gen_ready;
    gen_valid_d = grant || (gen_valid_q && !accept);
    gen_addr_d = grant ? bus.in_addr[idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] : gen_addr_q;
    gen_len_d = grant ? bus.in_len[idx*LEN_WIDTH +: LEN_WIDTH] : gen_len_q;
    gen_tag_d = grant ? bus.in_tag[idx*TAG_WIDTH +: TAG_WIDTH] : gen_tag_q;
    gen_port_d = grant ? idx : gen_port_q;
    rr_ptr_d = grant ? idx + 1'b1 : rr_ptr_q;
    cnt_d = accept && !her_done ? cnt_q + 1'b1 :
            her_done && !accept && cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
    err_d = err_q || (her_done && !accept && cnt_q == '0);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gen_valid_q <= 1'b0;
      gen_addr_q <= '0;
      gen_len_q <= '0;
      gen_tag_q <= '0;
      gen_port_q <= '0;
      rr_ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      gen_valid_q <= gen_valid_d;
      gen_addr_q <= gen_addr_d;
      gen_len_q <= gen_len_d;
      gen_tag_q <= gen_tag_d;
      gen_port_q <= gen_port_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus.in_ready = grant && rstn ? gnt : '0;
  assign bus.gen_valid = gen_valid_q;
  assign bus.gen_addr = gen_addr_q;
  assign bus.gen_len = gen_len_q;
  assign bus.gen_tag = gen_tag_q;
  assign bus.gen_port = gen_port_q;
  assign inflight_count = cnt_q;
  assign underflow_err = err_q;
endmodule

// File: tb/tb_pspin_her_arb.sv
// tb_pspin_her_arb: scoreboarded random and directed stimulus against a cycle-level reference model.
module tb_pspin_her_arb;
  localparam int N = 4, AW = 32, LW = 20, TW = 32, MAXI = 16, CW = 5, PW = 2;
  typedef struct {logic [AW-1:0] a; logic [LW-1:0] l; logic [TW-1:0] t; int p;} beat_t;
  logic clk = 0, rstn = 0, her_done = 0, enable = 0, gen_ready = 0, underflow_err;
  logic [CW-1:0] inflight_limit = '0, inflight_count;
  logic [AW-1:0] a[N];
  logic [LW-1:0] l[N];
  logic [TW-1:0] t[N];
  logic [N-1:0] v = '0, vmask = '0;
  logic [TW-1:0] tag_hold;
  beat_t exp_q[$];
  beat_t mon_e;
  int tests = 0, fails = 0;
  int m_rr = 0, m_cnt = 0, m_gport = -1, mode = 1;
  bit m_held = 0, m_err = 0;

  pspin_her_arb_if #(.NUM_PORTS(N), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW)) bus();
  pspin_her_arb #(.NUM_PORTS(N), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW),
                  .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rstn(rstn), .bus(bus), .her_done(her_done), .enable(enable),
    .inflight_limit(inflight_limit), .inflight_count(inflight_count), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.in_addr[i*AW +: AW] = a[i];
      bus.in_len[i*LW +: LW] = l[i];
      bus.in_tag[i*TW +: TW] = t[i];
    end
    bus.in_valid = v;
    bus.gen_ready = gen_ready;
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic newreq(input int p);
    a[p] = $urandom;
    l[p] = LW'($urandom);
    t[p] = $urandom;
  endtask

  // predict the grant from the rules, check, then advance the model across the edge
  task automatic step();
    int lim;
    bit can, free, acc;
    @(negedge clk);
    lim = inflight_limit > MAXI ? MAXI : int'(inflight_limit);
    can = enable && (m_cnt + int'(m_held)) < lim;
    free = !m_held || gen_ready;
    m_gport = -1;
    if (can && free)
      for (int k = 0; k < N; k++)
        if (m_gport < 0 && v[(m_rr + k) % N]) m_gport = (m_rr + k) % N;
    chk("in_ready", 64'(bus.in_ready), m_gport >= 0 ? 64'd1 << m_gport : 64'd0);
    chk("inflight_count", 64'(inflight_count), 64'(m_cnt));
    chk("underflow_err", 64'(underflow_err), 64'(m_err));
    if (m_gport >= 0) exp_q.push_back('{a[m_gport], l[m_gport], t[m_gport], m_gport});
    @(posedge clk);
    acc = m_held && gen_ready;
    if (acc && !her_done) m_cnt++;
    else if (her_done && !acc) begin
      if (m_cnt == 0) m_err = 1;
      else m_cnt--;
    end
    if (m_gport >= 0) begin
      m_held = 1;
      m_rr = (m_gport + 1) % N;
    end else if (acc) m_held = 0;
    #1;
    for (int p = 0; p < N; p++) begin
      if (mode == 1) begin
        if (p == m_gport) newreq(p);
        v[p] = vmask[p];
      end else begin
        if (p == m_gport) v[p] = 0;
        if (!v[p] && $urandom_range(99) < 50) begin
          newreq(p);
          v[p] = 1;
        end
      end
    end
  endtask

  // asynchronous assertion checked before any clock edge; release just after an edge
  task automatic do_reset();
    rstn = 0;
    #1;
    chk("rst_gen_valid", 64'(bus.gen_valid), 0);
    chk("rst_count", 64'(inflight_count), 0);
    chk("rst_err", 64'(underflow_err), 0);
    chk("rst_tag", 64'(bus.gen_tag), 0);
    exp_q.delete();
    m_rr = 0; m_cnt = 0; m_held = 0; m_err = 0;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    rstn = 1;
  endtask

  task automatic setup(input logic [N-1:0] m, input int lim, input bit rdy);
    do_reset();
    mode = 1; vmask = m; v = m;
    for (int p = 0; p < N; p++) newreq(p);
    inflight_limit = CW'(lim); gen_ready = rdy; her_done = 0; enable = 1;
  endtask

  always @(negedge clk)
    if (rstn && bus.gen_valid && gen_ready) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL beat_unexpected: port %0d tag %0h with no beat expected", bus.gen_port, bus.gen_tag);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_addr", 64'(bus.gen_addr), 64'(mon_e.a));
        chk("beat_len", 64'(bus.gen_len), 64'(mon_e.l));
        chk("beat_tag", 64'(bus.gen_tag), 64'(mon_e.t));
        chk("beat_port", 64'(bus.gen_port), 64'(mon_e.p));
      end
    end

  initial begin
    for (int p = 0; p < N; p++) newreq(p);
    v = '1;
    @(posedge clk);
    #1;
    setup(4'hF, 16, 1);
    her_done = 1;
    repeat (12) step();
    setup(4'hF, 2, 1);
    repeat (6) step();
    chk("limit2_count", 64'(inflight_count), 2);
    her_done = 1;
    step();
    her_done = 0;
    repeat (4) step();
    setup(4'b0100, 16, 0);
    step();
    tag_hold = exp_q[$].t;
    repeat (5) begin
      step();
      chk("stall_tag", 64'(bus.gen_tag), 64'(tag_hold));
    end
    gen_ready = 1;
    repeat (3) step();
    setup(4'b0001, 16, 1);
    repeat (4) step();
    chk("pre_coincide", 64'(inflight_count), 3);
    her_done = 1;
    step();
    chk("coincide", 64'(inflight_count), 3);
    setup(4'b0000, 16, 1);
    her_done = 1;
    step();
    her_done = 0;
    step();
    chk("underflow_count", 64'(inflight_count), 0);
    chk("underflow_flag", 64'(underflow_err), 1);
    setup(4'hF, 16, 1);
    repeat (6) step();
    chk("pre_reset_count", 64'(inflight_count), 5);
    do_reset();
    step();
    setup(4'hF, 16, 0);
    step();
    enable = 0;
    repeat (3) step();
    gen_ready = 1;
    repeat (3) step();
    enable = 1;
    repeat (3) step();
    mode = 0;
    repeat (3000) begin
      gen_ready = $urandom_range(99) < 70;
      her_done = $urandom_range(99) < 25;
      enable = $urandom_range(99) < 90;
      if ($urandom_range(99) < 5) inflight_limit = CW'($urandom_range(20));
      step();
    end
    enable = 0; gen_ready = 1; her_done = 0;
    repeat (3) step();
    chk("drain_queue", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
